// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus: command encodings, default widths
// and the copy-engine state type.
package mem_bus_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 9;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MWRITE = 2'b01;
  localparam logic [1:0] MREAD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR,
    DONE
  } mce_state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Bus-master block copier: moves len words from src_addr to dst_addr,
// one MREAD (held two cycles) followed by one MWRITE per word.
module mem_copy_engine
  import mem_bus_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] count,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] write_data
);

  mce_state_t        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        cmd_q, cmd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Bus outputs are computed for the state being entered so that the
  // registered values line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cmd_d   = MNONE;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = len;
          count_d = '0;
          if (len != '0) begin
            state_d = RD_ISSUE;
            cmd_d   = MREAD;
            addr_d  = src_addr;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_ISSUE: begin
        state_d = RD_WAIT;
        cmd_d   = MREAD;
        addr_d  = src_q;
      end
      RD_WAIT: begin
        // write_data doubles as the captured data register
        state_d = WR;
        cmd_d   = MWRITE;
        addr_d  = dst_q;
        wdata_d = read_data;
      end
      WR: begin
        src_d   = src_q + ADDR_W'(1);
        dst_d   = dst_q + ADDR_W'(1);
        count_d = count_q + ADDR_W'(1);
        rem_d   = rem_q - ADDR_W'(1);
        if (rem_q != ADDR_W'(1)) begin
          state_d = RD_ISSUE;
          cmd_d   = MREAD;
          addr_d  = src_q + ADDR_W'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cmd_q   <= MNONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign count      = count_q;
  assign mem_cmd    = cmd_q;
  assign mem_addr   = addr_q;
  assign write_data = wdata_q;

endmodule
